// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: default width and FSM encoding.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_addsub.sv
// Ripple add/sub: per-bit cell plus an N-bit chain built from it.
// op=0 gives a+b, op=1 gives a-b as a + ~b + 1 (cout=1 means no borrow).
module addsub_cell (
  input  logic a,
  input  logic b,
  input  logic op,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic bx;

  // Full adder on the conditionally inverted b operand.
  always_comb begin
    bx   = b ^ op;
    s    = a ^ bx ^ cin;
    cout = (a & bx) | (a & cin) | (bx & cin);
  end

endmodule : addsub_cell

module addsub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  // The op bit doubles as the carry-in so subtraction gets its +1.
  assign carry[0] = op;
  assign cout     = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    addsub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .op   (op),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule : addsub_n

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state, state_n;
  logic [WIDTH:0]   r, r_n;        // partial remainder, one guard bit
  logic [WIDTH-1:0] q, q_n;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d, d_n;        // captured divisor
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] quot_n, rem_n;
  logic             dz_n;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             no_borrow;

  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};

  addsub_n #(.N(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, d}),
    .op   (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign busy = (state == ST_CALC);
  assign done = (state == ST_FIN);

  // State and datapath registers; reset abandons any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      r           <= r_n;
      q           <= q_n;
      d           <= d_n;
      cnt         <= cnt_n;
      quotient    <= quot_n;
      remainder   <= rem_n;
      div_by_zero <= dz_n;
    end
  end

  // Next-state, operand capture and one restoring step per CALC cycle.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
    state_n = state;
    r_n     = r;
    q_n     = q;
    d_n     = d;
    cnt_n   = cnt;
    quot_n  = quotient;
    rem_n   = remainder;
    dz_n    = div_by_zero;

    case (state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          if (divisor == '0) begin
            // Division by zero resolves immediately with saturated quotient.
            state_n = ST_FIN;
            quot_n  = '1;
            rem_n   = dividend;
            dz_n    = 1'b1;
          end else begin
            state_n = ST_CALC;
            r_n     = '0;
            q_n     = dividend;
            d_n     = divisor;
            cnt_n   = CNT_W'(WIDTH - 1);
            dz_n    = 1'b0;
          end
        end else if (state == ST_FIN) begin
          state_n = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (no_borrow) begin
          r_n = diff;
          q_n = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_n = shifted;
          q_n = {q[WIDTH-2:0], 1'b0};
        end
        if (cnt == '0) begin
          // Last step: publish results so they are valid during FIN.
          state_n = ST_FIN;
          quot_n  = q_n;
          rem_n   = r_n[WIDTH-1:0];
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, multi-cycle corner sequences,
// and randomized invariant sweeps at WIDTH=8 and WIDTH=16.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [7:0]  quotient, remainder;

  logic        start16;
  logic [15:0] dividend16, divisor16;
  logic        busy16, done16, div_by_zero16;
  logic [15:0] quotient16, remainder16;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .reset       (reset),
    .start       (start16),
    .dividend    (dividend16),
    .divisor     (divisor16),
    .busy        (busy16),
    .done        (done16),
    .quotient    (quotient16),
    .remainder   (remainder16),
    .div_by_zero (div_by_zero16)
  );

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one 8-bit operation; returns cycles from accepting edge to done and busy cycles seen.
  // Inputs are scrambled right after acceptance to prove the DUT uses captured values.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
    if (lat != 0) begin
      @(negedge clk);
      check("done single-cycle", 32'(done), 32'd0);
    end
  endtask

  vec_t vecs[10];
  int   lat, bcnt, ndone;
  logic [7:0]  ra, rb;
  logic [15:0] wa, wb;

  initial begin
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3] = '{8'd77,  8'd0,   8'd255, 8'd77,  1'b1};
    vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[6] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    vecs[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[8] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
    vecs[9] = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};

    reset      = 1'b1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    start16    = 1'b0;
    dividend16 = '0;
    divisor16  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy",      32'(busy),        32'd0);
    check("reset done",      32'(done),        32'd0);
    check("reset quotient",  32'(quotient),    32'd0);
    check("reset remainder", 32'(remainder),   32'd0);
    check("reset dbz",       32'(div_by_zero), 32'd0);
    check("reset busy16",    32'(busy16),      32'd0);

    // Table-driven vectors.
    foreach (vecs[k]) begin
      do_op(vecs[k].dd, vecs[k].dv, lat, bcnt);
      check($sformatf("v%0d quotient",  k), 32'(quotient),    32'(vecs[k].q));
      check($sformatf("v%0d remainder", k), 32'(remainder),   32'(vecs[k].r));
      check($sformatf("v%0d dbz",       k), 32'(div_by_zero), 32'(vecs[k].z));
      check($sformatf("v%0d latency",   k), 32'(lat),         vecs[k].z ? 32'd1 : 32'd9);
      check($sformatf("v%0d busy cyc",  k), 32'(bcnt),        vecs[k].z ? 32'd0 : 32'd8);
    end

    // Start while busy is ignored; start in FIN is accepted back-to-back.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
    check("busy-ignore latency",   32'(lat),       32'd9);
    check("busy-ignore quotient",  32'(quotient),  32'd15);
    check("busy-ignore remainder", 32'(remainder), 32'd5);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
    check("b2b latency",   32'(lat),       32'd9);
    check("b2b quotient",  32'(quotient),  32'd10);
    check("b2b remainder", 32'(remainder), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid-reset busy",      32'(busy),        32'd0);
    check("mid-reset done",      32'(done),        32'd0);
    check("mid-reset quotient",  32'(quotient),    32'd0);
    check("mid-reset remainder", 32'(remainder),   32'd0);
    check("mid-reset dbz",       32'(div_by_zero), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abandoned op activity", 32'(ndone), 32'd0);
    do_op(8'd9, 8'd3, lat, bcnt);
    check("post-reset quotient",  32'(quotient),  32'd3);
    check("post-reset remainder", 32'(remainder), 32'd0);
    check("post-reset latency",   32'(lat),       32'd9);

    // Random sweep, WIDTH=8: invariant and latency.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (rb == 8'd0) rb = 8'd1;
      do_op(ra, rb, lat, bcnt);
      check($sformatf("rnd8 %0d/%0d invariant", ra, rb),
            32'((int'(quotient) * int'(rb) + int'(remainder) == int'(ra)) && (remainder < rb)),
            32'd1);
      check($sformatf("rnd8 %0d/%0d latency", ra, rb), 32'(lat), 32'd9);
    end

    // Random sweep, WIDTH=16.
    for (int i = 0; i < 300; i++) begin
      wa = 16'($urandom);
      wb = 16'($urandom);
      if (i % 4 == 0) wb = wb & 16'h00ff;
      if (wb == 16'd0) wb = 16'd1;
      @(negedge clk);
      dividend16 = wa;
      divisor16  = wb;
      start16    = 1'b1;
      @(posedge clk);
      #1 start16 = 1'b0;
      lat = 0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (done16) begin
          lat = j;
          break;
        end
        @(posedge clk);
      end
      check($sformatf("rnd16 %0d/%0d invariant", wa, wb),
            32'((longint'(quotient16) * longint'(wb) + longint'(remainder16) == longint'(wa))
                && (remainder16 < wb)),
            32'd1);
      check($sformatf("rnd16 %0d/%0d latency", wa, wb), 32'(lat), 32'd17);
      @(negedge clk);
      check("done16 single-cycle", 32'(done16), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seq_divider
